if_id_stage: RTL and testbench

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/hazard_detection_unit.sv | 19 +
 rtl/if_id_stage.sv | 101 ++++++++++
 tb/tb_if_id_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: datapath widths, the canonical NOP,
// the fetch FSM state encoding and a small PC-alignment helper.
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    // addi x0, x0, 0 -- decodes to no architectural effect.
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detect: a load in ID/EX whose destination feeds either
// source register of the instruction currently held for decode.
module hazard_detection_unit (
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rd_i,
    input  logic       if_id_valid_i,
    input  logic [4:0] if_id_rs1_i,
    input  logic [4:0] if_id_rs2_i,
    output logic       hazard_o
);

    logic rs_match;

    assign rs_match = (idex_rd_i == if_id_rs1_i) || (idex_rd_i == if_id_rs2_i);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign hazard_o = idex_memread_i && (idex_rd_i != 5'd0) && if_id_valid_i && rs_match;

endmodule

// File: rtl/if_id_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register: PC, fetch FSM,
// load-use stall and branch redirect handling.
module if_id_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            idex_memread,
    input  logic [4:0]      idex_rd,
    output logic [XLEN-1:0] if_id_pc,
    output logic [ILEN-1:0] if_id_instr,
    output logic            if_id_valid,
    output logic            bubble
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [ILEN-1:0] if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic            hazard;

    hazard_detection_unit u_hazard_detection_unit (
        .idex_memread_i (idex_memread),
        .idex_rd_i      (idex_rd),
        .if_id_valid_i  (if_id_valid_q),
        .if_id_rs1_i    (if_id_instr_q[19:15]),
        .if_id_rs2_i    (if_id_instr_q[24:20]),
        .hazard_o       (hazard)
    );

    // Redirect targets are word-aligned before use; the low bits are dropped.
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target[1:0];

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (branch_taken) begin
                    pc_d          = align_pc(branch_target);
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end else if (hazard) begin
                    // Stall: everything holds, the in-flight fetch is dropped.
                end else if (imem_ready) begin
                    if_id_pc_d    = pc_q;
                    if_id_instr_d = imem_rdata;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_q + XLEN'(4);
                end else begin
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign bubble      = hazard && !branch_taken;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed, table-driven bench for if_id_stage: each row applies inputs for
// one cycle, checks bubble before the edge and the registered outputs after.
module tb_if_id_stage;
    import riscv_pkg::*;

    logic            clk;
    logic            reset;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [ILEN-1:0] imem_rdata;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            idex_memread;
    logic [4:0]      idex_rd;
    logic [XLEN-1:0] if_id_pc;
    logic [ILEN-1:0] if_id_instr;
    logic            if_id_valid;
    logic            bubble;

    int checks   = 0;
    int failures = 0;

    if_id_stage dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .idex_memread  (idex_memread),
        .idex_rd       (idex_rd),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .bubble        (bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            rdy;
        logic [31:0]     rdata;
        logic            br;
        logic [63:0]     tgt;
        logic            mr;
        logic [4:0]      rd;
        logic            e_bubble;   // before the edge
        logic            e_req;      // after the edge
        logic [63:0]     e_addr;
        logic [63:0]     e_pc;
        logic [31:0]     e_instr;
        logic            e_valid;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic [31:0] rdata,
                         input logic br, input logic [63:0] tgt,
                         input logic mr, input logic [4:0] rd);
        reset         = rst;
        imem_ready    = rdy;
        imem_rdata    = rdata;
        branch_taken  = br;
        branch_target = tgt;
        idex_memread  = mr;
        idex_rd       = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic e_req, input logic [63:0] e_addr,
                              input logic [63:0] e_pc, input logic [31:0] e_instr,
                              input logic e_valid);
        check({tag, ".imem_req"},    64'(imem_req),    64'(e_req));
        check({tag, ".imem_addr"},   imem_addr,        e_addr);
        check({tag, ".if_id_pc"},    if_id_pc,         e_pc);
        check({tag, ".if_id_instr"}, 64'(if_id_instr), 64'(e_instr));
        check({tag, ".if_id_valid"}, 64'(if_id_valid), 64'(e_valid));
    endtask

    initial begin
        //            rst rdy rdata          br tgt                     mr rd   bub req addr                   pc                     instr          vld
        // Reset release: IDLE ignores fetch, then first fetch at PC 0.
        vecs[0]  = '{0, 1, 32'h00A0_0093, 0, 64'h0,                 0, 0,   0, 1, 64'h0,                 64'h0,                 NOP,          0};
        vecs[1]  = '{0, 1, 32'h00A0_0093, 0, 64'h0,                 0, 0,   0, 1, 64'h4,                 64'h0,                 32'h00A0_0093, 1};
        // add x2, x5, x6 enters decode.
        vecs[2]  = '{0, 1, 32'h0062_8133, 0, 64'h0,                 0, 0,   0, 1, 64'h8,                 64'h4,                 32'h0062_8133, 1};
        // Load to x5 (rs1) then x6 (rs2): stall, fetched data dropped.
        vecs[3]  = '{0, 1, JUNK,          0, 64'h0,                 1, 5,   1, 1, 64'h8,                 64'h4,                 32'h0062_8133, 1};
        vecs[4]  = '{0, 1, JUNK,          0, 64'h0,                 1, 6,   1, 1, 64'h8,                 64'h4,                 32'h0062_8133, 1};
        // Load to x0 never stalls.
        vecs[5]  = '{0, 1, 32'h0000_0513, 0, 64'h0,                 1, 0,   0, 1, 64'hC,                 64'h8,                 32'h0000_0513, 1};
        // Load to x7 with no matching source.
        vecs[6]  = '{0, 1, 32'h0052_8293, 0, 64'h0,                 1, 7,   0, 1, 64'h10,                64'hC,                 32'h0052_8293, 1};
        // Branch during hazard wins; target low bits cleared.
        vecs[7]  = '{0, 1, JUNK,          1, 64'h103,               1, 5,   0, 1, 64'h100,               64'hC,                 NOP,          0};
        // Same load still in ID/EX, but decode slot is empty: no hazard.
        vecs[8]  = '{0, 1, 32'h0010_0093, 0, 64'h0,                 1, 5,   0, 1, 64'h104,               64'h100,               32'h0010_0093, 1};
        // Three not-ready cycles: PC held, slot empty.
        vecs[9]  = '{0, 0, JUNK,          0, 64'h0,                 0, 0,   0, 1, 64'h104,               64'h100,               NOP,          0};
        vecs[10] = '{0, 0, JUNK,          0, 64'h0,                 0, 0,   0, 1, 64'h104,               64'h100,               NOP,          0};
        vecs[11] = '{0, 0, JUNK,          0, 64'h0,                 0, 0,   0, 1, 64'h104,               64'h100,               NOP,          0};
        vecs[12] = '{0, 1, 32'h0020_0113, 0, 64'h0,                 0, 0,   0, 1, 64'h108,               64'h104,               32'h0020_0113, 1};
        // lw x6, 0(x5) into decode, then load-use stall on x5.
        vecs[13] = '{0, 1, 32'h0002_A303, 0, 64'h0,                 0, 0,   0, 1, 64'h10C,               64'h108,               32'h0002_A303, 1};
        vecs[14] = '{0, 1, JUNK,          0, 64'h0,                 1, 5,   1, 1, 64'h10C,               64'h108,               32'h0002_A303, 1};
        // Reset during the stall overrides everything.
        vecs[15] = '{1, 1, JUNK,          0, 64'h0,                 1, 5,   1, 0, 64'h0,                 64'h0,                 NOP,          0};
        // IDLE ignores a branch.
        vecs[16] = '{0, 1, JUNK,          1, 64'h300,               1, 5,   0, 1, 64'h0,                 64'h0,                 NOP,          0};
        // Reset during a redirect.
        vecs[17] = '{1, 1, JUNK,          1, 64'h40,                0, 0,   0, 0, 64'h0,                 64'h0,                 NOP,          0};

        // Initial reset.
        drive(1, 0, 32'h0, 0, 64'h0, 0, 0);
        tick();
        tick();
        check_regs("reset", 1'b0, 64'h0, 64'h0, NOP, 1'b0);
        check("reset.bubble", 64'(bubble), 64'h0);

        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rdata, vecs[i].br, vecs[i].tgt,
                  vecs[i].mr, vecs[i].rd);
            #1;
            check({tag, ".bubble"}, 64'(bubble), 64'(vecs[i].e_bubble));
            tick();
            check_regs(tag, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_pc,
                       vecs[i].e_instr, vecs[i].e_valid);
        end

        // Bubble stays low right after reset even with a matching load in ID/EX.
        drive(0, 0, 32'h0, 0, 64'h0, 1, 5);
        #1;
        check("post_reset.bubble", 64'(bubble), 64'h0);

        // Wrap: redirect to the top word, fetch there, PC rolls to zero.
        tick();
        check_regs("wrap_idle", 1'b1, 64'h0, 64'h0, NOP, 1'b0);
        drive(0, 0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
        tick();
        check_regs("wrap_br", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, NOP, 1'b0);
        drive(0, 1, 32'h0030_0193, 0, 64'h0, 0, 0);
        tick();
        check_regs("wrap_fetch", 1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0030_0193, 1'b1);
        drive(0, 1, 32'h0040_0213, 0, 64'h0, 0, 0);
        tick();
        check_regs("wrap_next", 1'b1, 64'h4, 64'h0, 32'h0040_0213, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
